// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: the load-use interlock, branch flush and
// data-memory wait handling for a five-stage pipeline. It drives the PC and
// pipeline-register enables, and the IF/ID and ID/EX clears. It also keeps
// saturating stall and flush counters, and halts the pipeline when a memory
// access never completes.
module pipe_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             ex_br_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_clr_n,
   output logic             idex_clr_n,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, MWAIT, HALT} state_t;

   localparam logic [15:0]      TIMEOUT_V = TIMEOUT[15:0];
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t      state, state_nxt, state_eff;
   logic [15:0] wcnt, wcnt_nxt;
   logic        lu, ms;
   logic        run_eval;
   logic        stall_inc, flush_inc;

   // Hazard detection: load-use against a real (non-x0) load target, and an
   // outstanding memory access that does not complete this cycle.
   always_comb begin
      lu = ex_memread && (ex_rd != 5'd0) &&
           ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
      ms = mem_req && !mem_ready;
   end

   // Next state, wait counter and pipeline controls from state and hazards.
   // NOTE: every output gets a default before the case so no path can leave
   // one unassigned, which is what would otherwise infer a latch.
   always_comb begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      ifid_clr_n = 1'b1;
      idex_clr_n = 1'b1;
      halted     = 1'b0;
      state_nxt  = state;
      wcnt_nxt   = wcnt;
      run_eval   = 1'b0;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
      // While in reset the pipeline registers are held anyway, so present
      // the RUN behaviour regardless of the stored state.
      state_eff  = rstn ? state : RUN;

      case (state_eff)
         RUN: begin
            if (ms) begin
               {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
               stall_inc = 1'b1;
               wcnt_nxt  = 16'd1;
               state_nxt = (TIMEOUT_V <= 16'd1) ? HALT : MWAIT;
            end else begin
               run_eval = 1'b1;
            end
         end
         MWAIT: begin
            if (!mem_ready) begin
               {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
               stall_inc = 1'b1;
               wcnt_nxt  = wcnt + 16'd1;
               if (wcnt_nxt >= TIMEOUT_V) state_nxt = HALT;
            end else begin
               // Release cycle: any branch or load-use held frozen in EX/ID
               // during the wait is acted on now, exactly once.
               run_eval  = 1'b1;
               wcnt_nxt  = 16'd0;
               state_nxt = RUN;
            end
         end
         default: begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            halted = 1'b1;
         end
      endcase

      if (run_eval) begin
         if (ex_br_taken) begin
            ifid_clr_n = 1'b0;
            idex_clr_n = 1'b0;
            flush_inc  = 1'b1;
         end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_clr_n = 1'b0;
            stall_inc  = 1'b1;
         end
      end
   end

   // State, wait counter and saturating performance counters.
   // NOTE: rstn is sampled only at the clock edge (synchronous reset), and
   // all state uses non-blocking assignments so every register sees
   // pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= RUN;
         wcnt      <= 16'd0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
         if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Instance u_a uses TIMEOUT=4 for the halt
// scenario. Instance u_b uses CNT_W=2 for the saturation scenario. Both
// instances share the same stimulus.
module tb_pipe_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_memread, ex_br_taken, mem_req, mem_ready;

   logic        a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifclr, a_idclr, a_halted;
   logic [15:0] a_stall, a_flush;
   logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifclr, b_idclr, b_halted;
   logic [1:0]  b_stall, b_flush;

   pipe_ctrl #(.TIMEOUT(4), .CNT_W(16)) u_a (
      .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .ex_br_taken(ex_br_taken), .mem_req(mem_req),
      .mem_ready(mem_ready), .pc_en(a_pc), .ifid_en(a_ifid), .idex_en(a_idex),
      .exmem_en(a_exmem), .memwb_en(a_memwb), .ifid_clr_n(a_ifclr),
      .idex_clr_n(a_idclr), .halted(a_halted), .stall_cnt(a_stall), .flush_cnt(a_flush)
   );

   pipe_ctrl #(.TIMEOUT(255), .CNT_W(2)) u_b (
      .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .ex_br_taken(ex_br_taken), .mem_req(mem_req),
      .mem_ready(mem_ready), .pc_en(b_pc), .ifid_en(b_ifid), .idex_en(b_idex),
      .exmem_en(b_exmem), .memwb_en(b_memwb), .ifid_clr_n(b_ifclr),
      .idex_clr_n(b_idclr), .halted(b_halted), .stall_cnt(b_stall), .flush_cnt(b_flush)
   );

   // {pc, ifid, idex, exmem, memwb, ifid_clr_n, idex_clr_n}
   logic [6:0] a_vec, b_vec;
   assign a_vec = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifclr, a_idclr};
   assign b_vec = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifclr, b_idclr};

   localparam logic [6:0] V_NORM  = 7'b11111_11;
   localparam logic [6:0] V_STALL = 7'b00000_11;
   localparam logic [6:0] V_FLUSH = 7'b11111_00;
   localparam logic [6:0] V_LU    = 7'b00111_10;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_rd = 5'd0; ex_memread = 1'b0; ex_br_taken = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic set_lu();
      ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
      id_rs1 = 5'd3; id_use_rs1 = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset: outputs follow RUN equations, counters clear.
      idle();
      rstn = 1'b0;
      #1;
      check("rst_vec", a_vec, V_NORM);
      check("rst_halted_comb", a_halted, 1'b0);
      tick();
      check("rst_stall", a_stall, 16'd0);
      check("rst_flush", a_flush, 16'd0);
      check("rst_halted", a_halted, 1'b0);
      rstn = 1'b1;

      // Normal cycle.
      #1;
      check("norm_vec", a_vec, V_NORM);
      tick();

      // Load-use on rs2.
      set_lu();
      #1;
      check("lu_vec", a_vec, V_LU);
      tick();
      check("lu_stall", a_stall, 16'd1);
      check("lu_stall_b", b_stall, 2'd1);

      // ex_rd = 0 never interlocks.
      idle();
      ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
      #1;
      check("rd0_vec", a_vec, V_NORM);
      tick();
      // Matching register that is not actually read.
      ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0;
      #1;
      check("nouse_vec", a_vec, V_NORM);
      tick();
      check("nolu_stall", a_stall, 16'd1);

      // Branch together with a load-use: the flush wins.
      idle();
      set_lu();
      ex_br_taken = 1'b1;
      #1;
      check("br_lu_vec", a_vec, V_FLUSH);
      tick();
      check("br_flush", a_flush, 16'd1);
      check("br_stall", a_stall, 16'd1);

      // Request that completes in the same cycle: no stall.
      idle();
      mem_req = 1'b1; mem_ready = 1'b1;
      #1;
      check("req_rdy_vec", a_vec, V_NORM);
      tick();
      check("req_rdy_stall", a_stall, 16'd1);

      // Three stall cycles, then release.
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("ms_vec%0d", i), a_vec, V_STALL);
         tick();
      end
      mem_ready = 1'b1;
      #1;
      check("ms_release_vec", a_vec, V_NORM);
      tick();
      check("ms_stall", a_stall, 16'd4);
      idle();
      #1;
      check("ms_back_run", a_vec, V_NORM);
      check("ms_not_halted", a_halted, 1'b0);
      tick();

      // Branch held across a 2-cycle stall: one flush, on release only.
      ex_br_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check($sformatf("brms_vec%0d", i), a_vec, V_STALL);
         tick();
      end
      check("brms_no_flush_yet", a_flush, 16'd1);
      mem_ready = 1'b1;
      #1;
      check("brms_release_vec", a_vec, V_FLUSH);
      tick();
      check("brms_flush", a_flush, 16'd2);
      check("brms_stall", a_stall, 16'd6);

      // Load-use pending on release: one bubble on the release cycle.
      idle();
      mem_req = 1'b1; mem_ready = 1'b0;
      set_lu();
      #1;
      check("lums_vec", a_vec, V_STALL);
      tick();
      mem_ready = 1'b1;
      #1;
      check("lums_release_vec", a_vec, V_LU);
      tick();
      check("lums_stall", a_stall, 16'd8);

      // Timeout: u_a (TIMEOUT=4) halts after four stall cycles.
      idle();
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("to_vec%0d", i), a_vec, V_STALL);
         check($sformatf("to_halted_pre%0d", i), a_halted, 1'b0);
         tick();
      end
      check("to_halted", a_halted, 1'b1);
      check("to_b_not_halted", b_halted, 1'b0);
      check("to_stall", a_stall, 16'd12);
      // Further stimulus has no effect while halted.
      mem_ready = 1'b1; ex_br_taken = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check($sformatf("halt_vec%0d", i), a_vec, V_STALL);
         tick();
      end
      check("halt_stall_frozen", a_stall, 16'd12);
      check("halt_flush_frozen", a_flush, 16'd2);
      check("halt_still", a_halted, 1'b1);

      // Reset out of HALT.
      idle();
      rstn = 1'b0;
      #1;
      check("halt_rst_vec", a_vec, V_NORM);
      check("halt_rst_halted_comb", a_halted, 1'b0);
      tick();
      rstn = 1'b1;
      #1;
      check("post_rst_halted", a_halted, 1'b0);
      check("post_rst_stall", a_stall, 16'd0);
      check("post_rst_flush", a_flush, 16'd0);
      check("post_rst_vec", a_vec, V_NORM);
      tick();

      // Saturation: u_b (CNT_W=2) over five load-use cycles.
      set_lu();
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("sat_vec%0d", i), b_vec, V_LU);
         tick();
         check($sformatf("sat_b%0d", i), b_stall, (i < 3) ? 2'(i + 1) : 2'd3);
         check($sformatf("sat_a%0d", i), a_stall, 16'(i + 1));
      end

      idle();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max MEMWAIT cycles before halt (1..65535).
REQ-002 SHALL have parameter CNT_W, default 16, width of performance counters.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
REQ-007 ex_rd  in  5  destination register of the instruction in EX.
REQ-008 ex_memread  in  1  instruction in EX is a load.
REQ-009 ex_br_taken  in  1  branch/jump in EX resolved taken.
REQ-010 mem_req  in  1  MEM stage has a data-memory access outstanding this cycle.
REQ-011 mem_ready  in  1  data memory completes the access this cycle.
REQ-012 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  enable pins of the PC and pipeline registers.
REQ-013 ifid_clr_n, idex_clr_n  out  1 each  active-low synchronous clear, ANDed with rstn at the IF/ID and ID/EX registers.
REQ-014 halted  out  1  memory timeout occurred; pipeline frozen.
REQ-015 stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-016 SHALL implement registered FSM with states RUN, MWAIT, HALT; enable/clear outputs combinational from state and inputs.
REQ-017 Load-use hazard (LU) SHALL be: ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-018 Memory stall (MS) SHALL be: mem_req & !mem_ready.
REQ-019 Priority in RUN SHALL be MS > ex_br_taken > LU > normal.
REQ-020 RUN normal: all five enables 1, both clears 1.
REQ-021 RUN + MS: all enables 0, clears 1; next state MWAIT; wait counter loads 1.
REQ-022 RUN + ex_br_taken (no MS): all enables 1, ifid_clr_n=0, idex_clr_n=0 (two wrong-path instructions squashed); flush_cnt +1.
REQ-023 RUN + LU (no MS, no branch): pc_en=0, ifid_en=0, idex_en=1, idex_clr_n=0 (one bubble), exmem_en=1, memwb_en=1; stall_cnt +1.
REQ-024 MWAIT, mem_ready=0: all enables 0; wait counter +1; when counter reaches TIMEOUT, next state HALT.
REQ-025 MWAIT, mem_ready=1: release cycle, outputs evaluated exactly as RUN with MS=0 (pending ex_br_taken or LU applied this cycle); next state RUN; counter cleared.
REQ-026 Every cycle with all enables 0 in RUN or MWAIT SHALL increment stall_cnt.
REQ-027 HALT: all enables 0, clears 1, halted=1; exits only by reset; counters frozen.
REQ-028 ex_br_taken held stable during MWAIT (EX frozen) SHALL cause exactly one flush, on the release cycle.
REQ-029 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-030 mem_req=1 & mem_ready=1 in the same RUN cycle SHALL NOT stall.
REQ-031 ex_rd=0 SHALL never trigger LU.

Reset
REQ-032 rstn=0 at a clock edge SHALL force state RUN, wait counter 0, stall_cnt 0, flush_cnt 0, halted 0, including mid-MWAIT or HALT.
REQ-033 While rstn=0, outputs SHALL follow the RUN equations (pipeline registers are themselves in reset).

Verification
REQ-034 ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle -> pc_en=0, ifid_en=0, idex_clr_n=0 that cycle; stall_cnt 0->1.
REQ-035 ex_br_taken=1 with simultaneous LU -> all enables 1, both clears 0; flush_cnt +1, stall_cnt unchanged.
REQ-036 mem_req=1, mem_ready=0 for 3 cycles then ready=1 -> all enables 0 for 3 cycles, all 1 on 4th; stall_cnt=3; state RUN.
REQ-037 TIMEOUT=4, mem_req=1, mem_ready held 0 -> halted=1 after 4 stall cycles, enables stay 0 under further stimulus; rstn=0 one cycle -> halted=0, counters 0.
REQ-038 ex_br_taken=1 during a 2-cycle memory stall -> no clear during stall, ifid_clr_n=idex_clr_n=0 on release cycle only; flush_cnt=1.
REQ-039 CNT_W=2, 5 consecutive LU cycles -> stall_cnt saturates at 3.
